// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

  // Default divisor / quotient / remainder width; the dividend is twice this.
  localparam int DIV_WIDTH = 32;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] div_ext;
  logic [WIDTH:0] diff;
  logic           ge;

  // The quotient MSB shifts into the remainder. A set remainder MSB would put
  // the shifted value above 2^(WIDTH+1), which is always >= the divisor.
  assign rem_sh  = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
  assign div_ext = {1'b0, div_i};
  assign ge      = rem_i[WIDTH] | (rem_sh >= div_ext);
  assign diff    = rem_sh - div_ext;

  // Restore (keep the shifted value) or commit the subtraction, and shift in the quotient bit.
  always_comb begin
    rem_o = ge ? diff : rem_sh;
    quo_o = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential 2W/W unsigned restoring divider: one quotient bit per clock,
// with an immediate error result for divide-by-zero or quotient overflow.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] x,
  input  logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   r,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  localparam int              CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;
  logic [WIDTH-1:0] x_hi;
  logic [WIDTH-1:0] x_lo;

  assign x_hi = x[2*WIDTH-1:WIDTH];
  assign x_lo = x[WIDTH-1:0];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Next-state logic: accept or reject operands in IDLE, step in BUSY, and
  // publish results only when entering DONE so q/r/ovf stay stable otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    q_d     = q_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if ((y == '0) || (x_hi >= y)) begin
            // Quotient cannot fit in WIDTH bits (or y is zero): report at once.
            state_d = DONE;
            q_d     = '1;
            r_d     = x_lo;
            ovf_d   = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = '0;
            rem_d   = {1'b0, x_hi};
            quo_d   = x_lo;
            div_d   = y;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DONE;
          q_d     = step_quo;
          r_d     = step_rem[WIDTH-1:0];
          ovf_d   = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider (WIDTH = 32).
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] x;
  logic [31:0] y;
  logic [31:0] q;
  logic [31:0] r;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .x     (x),
    .y     (y),
    .q     (q),
    .r     (r),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and return how many cycles after the accepting edge
  // done was seen (1 = the cycle right after it), or -1 on timeout.
  task automatic run_op(input logic [63:0] xv, input logic [31:0] yv, output int lat);
    @(negedge clk);
    x = xv;
    y = yv;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    @(posedge clk);
    @(negedge clk);
    checks += 5;
    if (q !== 32'd0)   begin failures++; $display("FAIL reset_q: got %0h expected 0", q); end
    if (r !== 32'd0)   begin failures++; $display("FAIL reset_r: got %0h expected 0", r); end
    if (ovf !== 1'b0)  begin failures++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b expected 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_legal;
    logic [63:0] xv [4];
    logic [31:0] yv [4];
    logic [31:0] eq [4];
    logic [31:0] er [4];
    int lat;
    xv[0] = 64'd119;                 yv[0] = 32'd7;          eq[0] = 32'd17;         er[0] = 32'd0;
    xv[1] = 64'd120;                 yv[1] = 32'd7;          eq[1] = 32'd17;         er[1] = 32'd1;
    xv[2] = 64'hFFFFFFFE_FFFFFFFF;   yv[2] = 32'hFFFFFFFF;   eq[2] = 32'hFFFFFFFF;   er[2] = 32'hFFFFFFFE;
    xv[3] = 64'h00000004_FFFFFFFF;   yv[3] = 32'd5;          eq[3] = 32'hFFFFFFFF;   er[3] = 32'd4;
    for (int i = 0; i < 4; i++) begin
      run_op(xv[i], yv[i], lat);
      checks += 4;
      if (lat !== 33)    begin failures++; $display("FAIL legal%0d_latency: got %0d expected 33", i, lat); end
      if (q !== eq[i])   begin failures++; $display("FAIL legal%0d_q: got %0h expected %0h", i, q, eq[i]); end
      if (r !== er[i])   begin failures++; $display("FAIL legal%0d_r: got %0h expected %0h", i, r, er[i]); end
      if (ovf !== 1'b0)  begin failures++; $display("FAIL legal%0d_ovf: got %0b expected 0", i, ovf); end
      @(negedge clk);
      checks += 2;
      if (done !== 1'b0) begin failures++; $display("FAIL legal%0d_done_pulse: got %0b expected 0", i, done); end
      if (q !== eq[i])   begin failures++; $display("FAIL legal%0d_q_hold: got %0h expected %0h", i, q, eq[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [63:0] xv [3];
    logic [31:0] yv [3];
    logic [31:0] er [3];
    int lat;
    xv[0] = 64'd55;                yv[0] = 32'd0;  er[0] = 32'd55;
    xv[1] = 64'h00000005_00000000; yv[1] = 32'd5;  er[1] = 32'd0;
    xv[2] = 64'h00000004_00000009; yv[2] = 32'd4;  er[2] = 32'd9;
    for (int i = 0; i < 3; i++) begin
      run_op(xv[i], yv[i], lat);
      checks += 4;
      if (lat !== 1)            begin failures++; $display("FAIL ovf%0d_latency: got %0d expected 1", i, lat); end
      if (q !== 32'hFFFFFFFF)   begin failures++; $display("FAIL ovf%0d_q: got %0h expected ffffffff", i, q); end
      if (r !== er[i])          begin failures++; $display("FAIL ovf%0d_r: got %0h expected %0h", i, r, er[i]); end
      if (ovf !== 1'b1)         begin failures++; $display("FAIL ovf%0d_ovf: got %0b expected 1", i, ovf); end
    end
  endtask

  // Previous result is ffffffff / 9 / ovf=1; it must hold while 1000/7 runs.
  task automatic test_ignore_start;
    int lat;
    bit busy_gap;
    @(negedge clk);
    x = 64'd1000;
    y = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    busy_gap = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
      if (!busy) busy_gap = 1'b1;
      if (k == 11) begin
        x = 64'd50;
        y = 32'd3;
        start = 1'b1;
      end
      if (k == 12) begin
        start = 1'b0;
        x = 64'h0000_0000_0000_DEAD;
        y = 32'd1;
      end
      if (k == 20) begin
        checks += 3;
        if (q !== 32'hFFFFFFFF) begin failures++; $display("FAIL hold_q: got %0h expected ffffffff", q); end
        if (r !== 32'd9)        begin failures++; $display("FAIL hold_r: got %0h expected 9", r); end
        if (ovf !== 1'b1)       begin failures++; $display("FAIL hold_ovf: got %0b expected 1", ovf); end
      end
    end
    checks += 5;
    if (lat !== 33)       begin failures++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    if (busy_gap !== 1'b0) begin failures++; $display("FAIL ignore_busy_gap: got %0b expected 0", busy_gap); end
    if (q !== 32'd142)    begin failures++; $display("FAIL ignore_q: got %0d expected 142", q); end
    if (r !== 32'd6)      begin failures++; $display("FAIL ignore_r: got %0d expected 6", r); end
    if (ovf !== 1'b0)     begin failures++; $display("FAIL ignore_ovf: got %0b expected 0", ovf); end
    @(negedge clk);
    checks += 1;
    if (busy !== 1'b0)    begin failures++; $display("FAIL ignore_no_restart: busy got %0b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    int lat1;
    int lat2;
    @(negedge clk);
    x = 64'd100;
    y = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    lat1 = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat1 = k;
        break;
      end
    end
    checks += 3;
    if (lat1 !== 33)   begin failures++; $display("FAIL b2b1_latency: got %0d expected 33", lat1); end
    if (q !== 32'd11)  begin failures++; $display("FAIL b2b1_q: got %0d expected 11", q); end
    if (r !== 32'd1)   begin failures++; $display("FAIL b2b1_r: got %0d expected 1", r); end
    @(negedge clk);
    checks += 1;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: busy got %0b expected 0", busy); end
    x = 64'd77;
    y = 32'd8;
    @(posedge clk);
    #1;
    lat2 = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        lat2 = k;
        break;
      end
    end
    start = 1'b0;
    checks += 3;
    if (lat2 !== 33)   begin failures++; $display("FAIL b2b2_latency: got %0d expected 33", lat2); end
    if (q !== 32'd9)   begin failures++; $display("FAIL b2b2_q: got %0d expected 9", q); end
    if (r !== 32'd5)   begin failures++; $display("FAIL b2b2_r: got %0d expected 5", r); end
  endtask

  task automatic test_reset_mid;
    int lat;
    bit saw_activity;
    @(negedge clk);
    x = 64'd5000;
    y = 32'd13;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (q !== 32'd0)   begin failures++; $display("FAIL midrst_q: got %0h expected 0", q); end
    if (r !== 32'd0)   begin failures++; $display("FAIL midrst_r: got %0h expected 0", r); end
    if (ovf !== 1'b0)  begin failures++; $display("FAIL midrst_ovf: got %0b expected 0", ovf); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %0b expected 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_activity = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_activity = 1'b1;
    end
    checks += 1;
    if (saw_activity !== 1'b0) begin failures++; $display("FAIL midrst_no_done: got %0b expected 0", saw_activity); end
    run_op(64'd1000, 32'd3, lat);
    checks += 4;
    if (lat !== 33)    begin failures++; $display("FAIL after_rst_latency: got %0d expected 33", lat); end
    if (q !== 32'd333) begin failures++; $display("FAIL after_rst_q: got %0d expected 333", q); end
    if (r !== 32'd1)   begin failures++; $display("FAIL after_rst_r: got %0d expected 1", r); end
    if (ovf !== 1'b0)  begin failures++; $display("FAIL after_rst_ovf: got %0b expected 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
